// File: rtl/pipe_pkg.sv
// Shared definitions for the MIPS pipeline stage registers: default widths, the NOP encoding,
// the stage payload layout and the hold-counter width helper.
package pipe_pkg;

  localparam int PIPE_PC_W    = 32;
  localparam int PIPE_INSTR_W = 32;

  // sll $0,$0,0 -- the canonical MIPS bubble
  localparam logic [31:0] MIPS_NOP = 32'h0000_0000;

  typedef struct packed {
    logic [PIPE_PC_W-1:0]    pc;
    logic [PIPE_INSTR_W-1:0] instr;
    logic                    valid;
  } stage_payload_t;

  // Unlimited hold (0) only needs a sticky 1-bit flag; otherwise count up to max_hold without wrap.
  function automatic int hold_cnt_w(input int max_hold);
    return (max_hold < 1) ? 1 : $clog2(max_hold + 1);
  endfunction

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Handshake bundle between a pipeline stage register and its producer/hazard logic.
// Optional PIPE_STAGE_PERF_EN adds the stall/flush performance counters.
interface pipe_stage_reg_if
  import pipe_pkg::*;
#(
  parameter int PC_W    = PIPE_PC_W,
  parameter int INSTR_W = PIPE_INSTR_W
);

  logic [PC_W-1:0]    in_pc;
  logic [INSTR_W-1:0] in_instr;
  logic               in_valid;
  logic               hold;
  logic               flush;
  logic [PC_W-1:0]    out_pc;
  logic [INSTR_W-1:0] out_instr;
  logic               out_valid;
  logic               stalled;

`ifdef PIPE_STAGE_PERF_EN
  logic [31:0]        perf_stall_cnt;
  logic [31:0]        perf_flush_cnt;

  modport master (
    output in_pc, in_instr, in_valid, hold, flush,
    input  out_pc, out_instr, out_valid, stalled, perf_stall_cnt, perf_flush_cnt
  );

  modport slave (
    input  in_pc, in_instr, in_valid, hold, flush,
    output out_pc, out_instr, out_valid, stalled, perf_stall_cnt, perf_flush_cnt
  );
`else
  modport master (
    output in_pc, in_instr, in_valid, hold, flush,
    input  out_pc, out_instr, out_valid, stalled
  );

  modport slave (
    input  in_pc, in_instr, in_valid, hold, flush,
    output out_pc, out_instr, out_valid, stalled
  );
`endif

endinterface

// File: rtl/pipe_stage_reg_hold_limiter.sv
// Bounds consecutive stall cycles of a pipeline stage; produces the combinational stall decision.
// Flush always wins over hold and restarts the hold window.
module hold_limiter
  import pipe_pkg::*;
#(
  parameter int MAX_HOLD = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic hold,
  input  logic flush,
  output logic stalled
);

  localparam int              CNT_W     = hold_cnt_w(MAX_HOLD);
  localparam bit              UNLIMITED = (MAX_HOLD == 0);
  localparam logic [CNT_W-1:0] LIMIT    = UNLIMITED ? {CNT_W{1'b1}} : CNT_W'(MAX_HOLD);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             hold_req;
  logic             hold_eff;
  logic             force_advance;

  assign hold_req      = hold && !flush;
  assign hold_eff      = hold_req && (UNLIMITED || (cnt_q < LIMIT));
  assign force_advance = hold_req && !UNLIMITED && (cnt_q == LIMIT);

  // Every non-held edge (load, flush or forced advance) closes the current hold window.
  always_comb begin
    cnt_d = '0;
    if (force_advance) begin
      cnt_d = '0;
    end else if (hold_eff) begin
      cnt_d = (cnt_q == LIMIT) ? cnt_q : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign stalled = hold_eff && !rst;

endmodule

// File: rtl/pipe_stage_reg.sv
// Parametrised inter-stage pipeline register (IF/ID and later): 1-cycle latency, flush > bounded hold > load.
// Optional PIPE_STAGE_PERF_EN adds saturating stall/flush event counters.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int          PC_W      = PIPE_PC_W,
  parameter int          INSTR_W   = PIPE_INSTR_W,
  parameter int          MAX_HOLD  = 1,
  parameter logic [31:0] NOP_INSTR = MIPS_NOP
) (
  input logic              clk,
  input logic              rst,
  pipe_stage_reg_if.slave  bus
);

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
    logic               valid;
  } payload_t;

  localparam logic [INSTR_W-1:0] NOP_W = INSTR_W'(NOP_INSTR);

  logic     stalled;
  payload_t stage_q;

  hold_limiter #(
    .MAX_HOLD (MAX_HOLD)
  ) u_hold_limiter (
    .clk     (clk),
    .rst     (rst),
    .hold    (bus.hold),
    .flush   (bus.flush),
    .stalled (stalled)
  );

  // A flushed slot keeps the incoming PC so downstream debug still sees where the bubble came from.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage_q.pc    <= '0;
      stage_q.instr <= NOP_W;
      stage_q.valid <= 1'b0;
    end else if (bus.flush) begin
      stage_q.pc    <= bus.in_pc;
      stage_q.instr <= NOP_W;
      stage_q.valid <= 1'b0;
    end else if (!stalled) begin
      stage_q.pc    <= bus.in_pc;
      stage_q.instr <= bus.in_instr;
      stage_q.valid <= bus.in_valid;
    end
  end

  assign bus.out_pc    = stage_q.pc;
  assign bus.out_instr = stage_q.instr;
  assign bus.out_valid = stage_q.valid;
  assign bus.stalled   = stalled;

`ifdef PIPE_STAGE_PERF_EN
  logic [31:0] perf_stall_q;
  logic [31:0] perf_flush_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_stall_q <= '0;
      perf_flush_q <= '0;
    end else begin
      if (stalled && (perf_stall_q != 32'hFFFF_FFFF)) begin
        perf_stall_q <= perf_stall_q + 32'd1;
      end
      if (bus.flush && (perf_flush_q != 32'hFFFF_FFFF)) begin
        perf_flush_q <= perf_flush_q + 32'd1;
      end
    end
  end

  assign bus.perf_stall_cnt = perf_stall_q;
  assign bus.perf_flush_cnt = perf_flush_q;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg with MAX_HOLD = 1, 0 (unlimited) and 3.
// Checks perf counters as well when PIPE_STAGE_PERF_EN is defined.
module tb_pipe_stage_reg;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  pipe_stage_reg_if #(.PC_W(32), .INSTR_W(32)) b1 ();
  pipe_stage_reg_if #(.PC_W(32), .INSTR_W(32)) b0 ();
  pipe_stage_reg_if #(.PC_W(32), .INSTR_W(32)) b3 ();

  pipe_stage_reg #(.PC_W(32), .INSTR_W(32), .MAX_HOLD(1), .NOP_INSTR(32'h0000_0000))
    u1 (.clk(clk), .rst(rst), .bus(b1));
  pipe_stage_reg #(.PC_W(32), .INSTR_W(32), .MAX_HOLD(0), .NOP_INSTR(32'h0000_0000))
    u0 (.clk(clk), .rst(rst), .bus(b0));
  pipe_stage_reg #(.PC_W(32), .INSTR_W(32), .MAX_HOLD(3), .NOP_INSTR(32'hDEAD_BEEF))
    u3 (.clk(clk), .rst(rst), .bus(b3));

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        valid;
    logic        hold;
    logic        flush;
    logic        e_stalled;
    logic [31:0] e_pc;
    logic [31:0] e_instr;
    logic        e_valid;
  } vec_t;

  vec_t tv[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] exp_pc;
    logic        exp_st;

    // MAX_HOLD=1 sequence: alternate hold/advance, flush beats hold, hold drop clears window
    tv[0]  = '{32'h0,   32'h11,        1'b1, 1'b0, 1'b0, 1'b0, 32'h0,   32'h11, 1'b1};
    tv[1]  = '{32'h4,   32'h22,        1'b1, 1'b1, 1'b0, 1'b1, 32'h0,   32'h11, 1'b1};
    tv[2]  = '{32'h8,   32'h33,        1'b1, 1'b1, 1'b0, 1'b0, 32'h8,   32'h33, 1'b1};
    tv[3]  = '{32'hC,   32'h44,        1'b1, 1'b1, 1'b0, 1'b1, 32'h8,   32'h33, 1'b1};
    tv[4]  = '{32'h10,  32'h55,        1'b1, 1'b1, 1'b0, 1'b0, 32'h10,  32'h55, 1'b1};
    tv[5]  = '{32'h200, 32'h8C08_0004, 1'b1, 1'b1, 1'b1, 1'b0, 32'h200, 32'h0,  1'b0};
    tv[6]  = '{32'h204, 32'h66,        1'b1, 1'b1, 1'b0, 1'b1, 32'h200, 32'h0,  1'b0};
    tv[7]  = '{32'h208, 32'h77,        1'b0, 1'b0, 1'b0, 1'b0, 32'h208, 32'h77, 1'b0};
    tv[8]  = '{32'h20C, 32'h88,        1'b1, 1'b1, 1'b0, 1'b1, 32'h208, 32'h77, 1'b0};
    tv[9]  = '{32'h210, 32'h99,        1'b1, 1'b0, 1'b0, 1'b0, 32'h210, 32'h99, 1'b1};
    tv[10] = '{32'h214, 32'hAA,        1'b1, 1'b1, 1'b0, 1'b1, 32'h210, 32'h99, 1'b1};
    tv[11] = '{32'h218, 32'hBB,        1'b1, 1'b0, 1'b0, 1'b0, 32'h218, 32'hBB, 1'b1};

    rst = 1'b1;
    b1.in_pc = '0; b1.in_instr = '0; b1.in_valid = 1'b0; b1.hold = 1'b1; b1.flush = 1'b0;
    b0.in_pc = '0; b0.in_instr = '0; b0.in_valid = 1'b0; b0.hold = 1'b0; b0.flush = 1'b0;
    b3.in_pc = '0; b3.in_instr = '0; b3.in_valid = 1'b0; b3.hold = 1'b0; b3.flush = 1'b0;
    tick();
    tick();

    chk("rst_pc",      b1.out_pc,    32'h0);
    chk("rst_instr",   b1.out_instr, 32'h0);
    chk("rst_valid",   b1.out_valid, 32'h0);
    chk("rst_stalled", b1.stalled,   32'h0);
    chk("rst_nop3",    b3.out_instr, 32'hDEAD_BEEF);

    // Reset asserted mid-cycle takes effect without a clock edge
    rst = 1'b0;
    b1.hold = 1'b0;
    b1.in_pc = 32'h80; b1.in_instr = 32'h1234; b1.in_valid = 1'b1;
    tick();
    chk("pre_rst_pc", b1.out_pc, 32'h80);
    b1.in_pc = 32'h40;
    b1.hold = 1'b1;
    #3;
    rst = 1'b1;
    #1;
    chk("mid_rst_pc",      b1.out_pc,    32'h0);
    chk("mid_rst_instr",   b1.out_instr, 32'h0);
    chk("mid_rst_valid",   b1.out_valid, 32'h0);
    chk("mid_rst_stalled", b1.stalled,   32'h0);
    b1.hold = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    chk("post_rst_pc",    b1.out_pc,    32'h40);
    chk("post_rst_valid", b1.out_valid, 32'h1);

    for (int i = 0; i < 12; i++) begin
      b1.in_pc = tv[i].pc; b1.in_instr = tv[i].instr; b1.in_valid = tv[i].valid;
      b1.hold = tv[i].hold; b1.flush = tv[i].flush;
      #1;
      chk($sformatf("tv%0d_stalled", i), b1.stalled, tv[i].e_stalled);
      tick();
      chk($sformatf("tv%0d_pc", i),    b1.out_pc,    tv[i].e_pc);
      chk($sformatf("tv%0d_instr", i), b1.out_instr, tv[i].e_instr);
      chk($sformatf("tv%0d_valid", i), b1.out_valid, tv[i].e_valid);
    end
    b1.hold = 1'b0; b1.flush = 1'b0;

    // Unlimited hold: stays frozen for 10 cycles, then loads the current input
    b0.in_pc = 32'h100; b0.in_instr = 32'h2108_0001; b0.in_valid = 1'b1;
    tick();
    chk("unl_load_pc", b0.out_pc, 32'h100);
    for (int i = 0; i < 10; i++) begin
      b0.hold = 1'b1;
      b0.in_pc = 32'h104 + 32'(4 * i);
      #1;
      chk($sformatf("unl%0d_stalled", i), b0.stalled, 32'h1);
      tick();
      chk($sformatf("unl%0d_pc", i), b0.out_pc, 32'h100);
    end
    b0.hold = 1'b0;
    b0.in_pc = 32'h300;
    #1;
    chk("unl_release_stalled", b0.stalled, 32'h0);
    tick();
    chk("unl_release_pc", b0.out_pc, 32'h300);

    // Flush with hold on the unlimited instance
    b0.hold = 1'b1; b0.flush = 1'b1;
    b0.in_pc = 32'h200; b0.in_instr = 32'h8C08_0004; b0.in_valid = 1'b1;
    #1;
    chk("fh_stalled", b0.stalled, 32'h0);
    tick();
    chk("fh_pc",    b0.out_pc,    32'h200);
    chk("fh_instr", b0.out_instr, 32'h0);
    chk("fh_valid", b0.out_valid, 32'h0);
    b0.hold = 1'b0; b0.flush = 1'b0;

    // MAX_HOLD=3: three held cycles then one forced advance, repeating
    b3.in_pc = 32'h1000; b3.in_instr = 32'h5; b3.in_valid = 1'b1;
    tick();
    chk("mh3_load_pc", b3.out_pc, 32'h1000);
    exp_pc = 32'h1000;
    for (int i = 0; i < 8; i++) begin
      b3.hold = 1'b1;
      b3.in_pc = 32'h1004 + 32'(4 * i);
      exp_st = ((i % 4) != 3);
      #1;
      chk($sformatf("mh3_%0d_stalled", i), b3.stalled, {31'b0, exp_st});
      tick();
      if (!exp_st) exp_pc = 32'h1004 + 32'(4 * i);
      chk($sformatf("mh3_%0d_pc", i), b3.out_pc, exp_pc);
    end
    b3.hold = 1'b0;
    tick();

`ifdef PIPE_STAGE_PERF_EN
    rst = 1'b1;
    #1;
    chk("perf_rst_stall", b0.perf_stall_cnt, 32'd0);
    chk("perf_rst_flush", b0.perf_flush_cnt, 32'd0);
    tick();
    rst = 1'b0;
    b0.hold = 1'b1;
    repeat (5) tick();
    b0.hold = 1'b0;
    b0.flush = 1'b1;
    repeat (2) tick();
    b0.flush = 1'b0;
    tick();
    chk("perf_stall", b0.perf_stall_cnt, 32'd5);
    chk("perf_flush", b0.perf_flush_cnt, 32'd2);
    rst = 1'b1;
    #1;
    chk("perf_clr_stall", b0.perf_stall_cnt, 32'd0);
    chk("perf_clr_flush", b0.perf_flush_cnt, 32'd0);
    tick();
    rst = 1'b0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
